// File: rtl/scoreboard_pkg.sv
// Shared constants for the scoreboard display path: seven-segment codes
// (active-high, gfedcba), score width and the scan-decoder FSM encoding.
package scoreboard_pkg;

  localparam int SCORE_W = 16;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    REPORT  = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_to_digit.sv
// Combinational seven-segment to decimal decoder. Blank decodes as digit 0
// with blank=1; any unlisted pattern gives valid=0.
module seg7_to_digit
  import scoreboard_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       blank,
  output logic       valid
);

  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    valid = 1'b1;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/scoreboard_scan_decoder.sv
// Passive monitor of the multiplexed seven-segment bus: rebuilds each scan
// frame and converts it to a binary score. Optional watchdog: SCOREDEC_TIMEOUT_EN.
module scoreboard_scan_decoder
  import scoreboard_pkg::*;
#(
  parameter int NUM_DIGITS       = 8,
  parameter int SCORE_DIGITS     = 5,
  parameter bit SHIFT_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter int TIMEOUT_CYCLES   = 2000
) (
  input  logic                  R_clk_1000HZ,
  input  logic                  I_rst_n,
  input  logic [NUM_DIGITS-1:0] I_shift,
  input  logic [6:0]            I_data,
  output logic [SCORE_W-1:0]    O_score,
  output logic                  O_valid,
  output logic                  O_err,
  output logic                  O_stall
);

  localparam int IDX_W  = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;
  localparam int ACC_WW = SCORE_W + 5;

  logic [NUM_DIGITS-1:0] sel;
  logic [NUM_DIGITS-1:0] cap_mask;
  logic [NUM_DIGITS-1:0] seen_reg;
  logic [NUM_DIGITS-1:0] bad_vec;
  logic [6:0]            seg_in;
  logic [6:0]            slot_reg [NUM_DIGITS];
  logic [6:0]            buf_reg  [NUM_DIGITS];
  logic [3:0]            dig      [SCORE_DIGITS];
  logic                  frame_done;
  logic                  frame_bad;
  logic                  load_buf;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [SCORE_W:0]      acc_reg, acc_next;
  logic                  ovf_reg, ovf_next;
  logic [SCORE_W-1:0]    score_next;
  logic                  valid_next, err_next;
  logic [3:0]            cur_digit;
  logic [ACC_WW-1:0]     acc_wide;

  assign sel    = SHIFT_ACTIVE_LOW ? ~I_shift : I_shift;
  assign seg_in = SEG_ACTIVE_LOW   ? ~I_data  : I_data;

  // Only a clean one-hot select identifies a digit; glitches are ignored.
  assign cap_mask   = ((sel != '0) && ((sel & (sel - 1'b1)) == '0)) ? sel : '0;
  assign frame_done = &seen_reg;
  assign frame_bad  = |bad_vec;

  always_ff @(posedge R_clk_1000HZ or negedge I_rst_n) begin
    if (!I_rst_n) begin
      seen_reg <= '0;
    end else begin
      seen_reg <= (frame_done ? '0 : seen_reg) | cap_mask;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
      logic [3:0] seg_digit;
      logic       seg_blank;
      logic       seg_valid;

      always_ff @(posedge R_clk_1000HZ or negedge I_rst_n) begin
        if (!I_rst_n) begin
          slot_reg[gi] <= '0;
        end else if (cap_mask[gi]) begin
          slot_reg[gi] <= seg_in;
        end
      end

      // Frozen copy so the next frame can be captured during conversion.
      always_ff @(posedge R_clk_1000HZ or negedge I_rst_n) begin
        if (!I_rst_n) begin
          buf_reg[gi] <= '0;
        end else if (load_buf) begin
          buf_reg[gi] <= slot_reg[gi];
        end
      end

      seg7_to_digit u_dec (
        .seg   (buf_reg[gi]),
        .digit (seg_digit),
        .blank (seg_blank),
        .valid (seg_valid)
      );

      if (gi < SCORE_DIGITS) begin : g_score
        assign dig[gi]     = seg_blank ? 4'd0 : seg_digit;
        assign bad_vec[gi] = ~seg_valid;
      end else begin : g_upper
        assign bad_vec[gi] = ~seg_valid | (~seg_blank & (seg_digit != 4'd0));
      end
    end
  endgenerate

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) cur_digit = dig[i];
    end
  end

  assign acc_wide = ACC_WW'(acc_reg) * ACC_WW'(10) + ACC_WW'(cur_digit);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    acc_next   = acc_reg;
    ovf_next   = ovf_reg;
    score_next = O_score;
    valid_next = 1'b0;
    err_next   = 1'b0;
    load_buf   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_done) begin
          load_buf   = 1'b1;
          acc_next   = '0;
          ovf_next   = 1'b0;
          idx_next   = IDX_W'(SCORE_DIGITS - 1);
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        acc_next = acc_wide[SCORE_W:0];
        ovf_next = ovf_reg | (|acc_wide[ACC_WW-1:SCORE_W+1]);
        if (idx_reg == '0) begin
          state_next = REPORT;
        end else begin
          idx_next = idx_reg - 1'b1;
        end
      end
      REPORT: begin
        if (frame_bad || ovf_reg || acc_reg[SCORE_W]) begin
          err_next = 1'b1;
        end else begin
          score_next = acc_reg[SCORE_W-1:0];
          valid_next = 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge R_clk_1000HZ or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      O_score   <= '0;
      O_valid   <= 1'b0;
      O_err     <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      acc_reg   <= acc_next;
      ovf_reg   <= ovf_next;
      O_score   <= score_next;
      O_valid   <= valid_next;
      O_err     <= err_next;
    end
  end

`ifdef SCOREDEC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wd_reg;

  always_ff @(posedge R_clk_1000HZ or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wd_reg <= '0;
    end else if (frame_done) begin
      wd_reg <= '0;
    end else if (wd_reg != TO_W'(TIMEOUT_CYCLES)) begin
      wd_reg <= wd_reg + 1'b1;
    end
  end

  assign O_stall = (wd_reg == TO_W'(TIMEOUT_CYCLES));
`else
  // Watchdog not built; the limit has no effect in this configuration.
  assign O_stall = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: doc/scoreboard_scan_decoder.md
Name: scoreboard_scan_decoder

Overview:
- Passive monitor on the multiplexed 8-digit seven-segment bus (O_shift digit select, O_data segments) that the scoreboard driver produces.
- Samples each scanned digit, decodes segment patterns back to decimal digits, and reconverts a full scan frame into a 16-bit binary score.
- Reports the score with a valid pulse and an error flag.
- Used for on-chip self-check of the score display and as the bench checker for the scoreboard driver.

Parameters:
- NUM_DIGITS, 8: scan positions on the bus; width of I_shift.
- SCORE_DIGITS, 5: low-order positions converted to binary (65535 needs 5 digits).
- SHIFT_ACTIVE_LOW, 1: 1 means the selected digit is the 0 bit of I_shift.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment is a 0 bit of I_data.
- TIMEOUT_CYCLES, 2000: frame watchdog limit; used only with the optional feature.

Ports:
- R_clk_1000HZ, input, 1: scan clock, the same clock as the scoreboard driver.
- I_rst_n, input, 1: asynchronous active-low reset.
- I_shift, input, NUM_DIGITS: digit select observed on the bus.
- I_data, input, 7: segment bus, bit0=a through bit6=g.
- O_score, output, 16: last successfully decoded score.
- O_valid, output, 1: one-cycle pulse when O_score is updated.
- O_err, output, 1: one-cycle pulse when a completed frame is rejected.
- O_stall, output, 1: watchdog flag; exists only with the optional feature.

Behaviour:
- Reset (asynchronous, I_rst_n=0): O_score=0, O_valid=0, O_err=0, O_stall=0. Seen-mask, slot registers, accumulator and FSM are cleared; FSM goes to IDLE.
- Normalisation: invert I_shift and I_data according to the polarity parameters. All later rules use the active-high values.
- Capture, every cycle, independent of FSM state:
  - If the normalised select is exactly one-hot at position k, store the normalised segments in slot[k] and set seen[k].
  - Zero-hot or multi-hot select is ignored; no slot is written.
  - A repeated position overwrites its slot.
- Segment decode (active-high, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 00 (blank) decodes as 0.
  - Any other pattern is invalid.
- Frame complete: the cycle in which seen becomes all-ones.
  - Next cycle: snapshot all slots into a conversion buffer, clear seen, and move FSM IDLE->CONVERT.
  - If a frame completes while not in IDLE, it is dropped: seen is cleared and nothing else happens.
- FSM:
  - IDLE: waits for frame complete.
  - CONVERT: runs SCORE_DIGITS cycles, most significant digit first; acc <= acc*10 + digit. acc is 17 bits wide; any carry out of bit 16 is recorded as overflow.
  - REPORT: takes one cycle, then returns to IDLE.
- Error conditions (frame rejected):
  - any invalid pattern in any slot;
  - a non-blank, non-zero pattern in a slot at index >= SCORE_DIGITS;
  - acc > 65535.
- REPORT outcome:
  - Rejected frame: pulse O_err; O_score holds its previous value.
  - Otherwise: O_score <= acc[15:0] and pulse O_valid.
- O_valid and O_err are never high in the same cycle.
- Latency: O_valid or O_err is high exactly SCORE_DIGITS+2 cycles after the frame-complete cycle.
- Reset mid-CONVERT aborts the conversion; no pulse is produced.

Optional Feature:
- Macro: SCOREDEC_TIMEOUT_EN.
- Defined:
  - A counter clears on each frame-complete cycle and otherwise increments, saturating.
  - O_stall=1 while the counter >= TIMEOUT_CYCLES.
  - O_stall clears in the cycle after the next frame completes.
- Undefined: O_stall is tied to 0 and the counter is not built.

Decomposition:
- Package scoreboard_pkg holds:
  - the SEG_0..SEG_9 and SEG_BLANK constants;
  - the FSM state encoding (IDLE, CONVERT, REPORT);
  - SCORE_W=16.
- One sub-module, seg7_to_digit (combinational): input 7-bit pattern; outputs a 4-bit digit, a blank flag and a valid flag. Instantiated once per SCORE_DIGITS slot and reused for the upper-slot check.

Test Plan:
- Scan the patterns for score 0 (digits 0..4 show "0", upper positions blank) -> O_valid after 7 cycles with O_score=0.
- Sequential frames for scores 5, 60, 198 and 2378, each a full 8-position scan -> four O_valid pulses with O_score 5, 60, 198, 2378, in order.
- Frame with slot 2 pattern 0x49 -> O_err pulse; O_score keeps the prior value 2378; O_valid stays 0.
- Digits "70000" (exceeds 65535) -> O_err. Slot 6 showing "1" -> O_err.
- Multi-hot select 0x03 and zero-hot select injected mid-frame -> ignored; frame completes normally to 198.
- With SCOREDEC_TIMEOUT_EN and TIMEOUT_CYCLES=50:
  - stop scanning for 60 cycles -> O_stall=1;
  - resume a full frame -> O_stall=0.
  - Assert I_rst_n=0 during CONVERT -> all outputs are 0 immediately; no pulse follows.
